// File: rtl/rs232_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// rs232_rx_fifo_if
// Signal bundle between the RS232R receiver / CPU I/O bus and the receive FIFO.
//   Receiver side : rx_data (byte), rx_rdy (byte held), rx_done (acknowledge)
//   CPU side      : rd (pop head), dout (head byte), rdy (non-empty),
//                   count (stored entries), ovf (sticky overrun), clr_ovf
// Modports:
//   master - the environment (receiver + CPU bus) driving the FIFO
//   slave  - the FIFO itself
// ----------------------------------------------------------------------------
interface rs232_rx_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic [7:0]          rx_data;
   logic                rx_rdy;
   logic                rx_done;
   logic                rd;
   logic [7:0]          dout;
   logic                rdy;
   logic [DEPTH_LOG2:0] count;
   logic                ovf;
   logic                clr_ovf;

   modport master (
      output rx_data, rx_rdy, rd, clr_ovf,
      input  rx_done, dout, rdy, count, ovf
   );

   modport slave (
      input  rx_data, rx_rdy, rd, clr_ovf,
      output rx_done, dout, rdy, count, ovf
   );
endinterface

// File: rtl/rs232_rx_fifo.sv
// ----------------------------------------------------------------------------
// rs232_rx_fifo
// Receive buffer between the RS232R serial receiver and the CPU I/O bus.
// Each byte held by the receiver is drained through the rdy/done handshake
// into a 2**DEPTH_LOG2 entry FIFO; the CPU sees the head byte (show-ahead)
// and a non-empty flag in the same form RS232R presents them.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active low
//   bus  - rs232_rx_fifo_if.slave (rx_data/rx_rdy/rx_done receiver handshake,
//          rd/dout/rdy/count CPU read side, ovf/clr_ovf overrun status)
//
// Build option:
//   RXFIFO_OVERRUN_EN - when defined, a byte arriving at a full FIFO is
//   acknowledged and dropped and the sticky ovf flag is set. When undefined,
//   the byte is left in the receiver until space frees up and ovf reads 0.
// ----------------------------------------------------------------------------
module rs232_rx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input logic             clk,
   input logic             rst,
   rs232_rx_fifo_if.slave  bus
);
   localparam int AW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {CAP_IDLE, CAP_WAIT} cap_state_e;

   cap_state_e       state_q, state_d;
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    count_q, count_d;
   logic             rx_done_q, rx_done_d;
   logic             ovf_q, ovf_d;
   logic             wr_en;
   logic             pop;
   logic             full;
   logic             can_accept;
   logic [7:0]       mem_q [DEPTH];

`ifndef RXFIFO_OVERRUN_EN
   // clr_ovf has no effect when overrun detection is not built in.
   logic unused_clr_ovf;
   assign unused_clr_ovf = bus.clr_ovf;
`endif

   always_comb begin
      state_d   = state_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      count_d   = count_q;
      rx_done_d = 1'b0;
      ovf_d     = ovf_q;
      wr_en     = 1'b0;

      full = (count_q == CW'(DEPTH));
      pop  = bus.rd && (count_q != '0);
      // A full FIFO still accepts when the head is popped in the same cycle.
      can_accept = !full || bus.rd;

      case (state_q)
         CAP_IDLE: begin
            if (bus.rx_rdy) begin
               if (can_accept) begin
                  wr_en     = 1'b1;
                  rx_done_d = 1'b1;
                  state_d   = CAP_WAIT;
               end
`ifdef RXFIFO_OVERRUN_EN
               else begin
                  // Drain the receiver anyway; the newest byte is lost.
                  rx_done_d = 1'b1;
                  state_d   = CAP_WAIT;
               end
`endif
            end
         end
         CAP_WAIT: begin
            // Wait for the receiver to drop rdy so each byte is taken once.
            if (!bus.rx_rdy) begin
               state_d = CAP_IDLE;
            end
         end
         default: state_d = CAP_IDLE;
      endcase

      if (wr_en) begin
         wp_d = wp_q + AW'(1);
      end
      if (pop) begin
         rp_d = rp_q + AW'(1);
      end
      if (wr_en && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!wr_en && pop) begin
         count_d = count_q - CW'(1);
      end

`ifdef RXFIFO_OVERRUN_EN
      // Set has priority over a simultaneous clear.
      ovf_d = (ovf_q && !bus.clr_ovf) ||
              (state_q == CAP_IDLE && bus.rx_rdy && !can_accept);
`else
      ovf_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= CAP_IDLE;
         wp_q      <= '0;
         rp_q      <= '0;
         count_q   <= '0;
         rx_done_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         count_q   <= count_d;
         rx_done_q <= rx_done_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage is not reset; entries are only observed while rdy is high.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wp_q] <= bus.rx_data;
      end
   end

   assign bus.dout    = mem_q[rp_q];
   assign bus.rdy     = (count_q != '0);
   assign bus.count   = count_q;
   assign bus.rx_done = rx_done_q;
   assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_rs232_rx_fifo
// Directed bench for rs232_rx_fifo (DEPTH_LOG2 = 4). Models the RS232R side
// of the handshake (hold rdy until done, drop it one edge later) and the CPU
// read strobe. Build with or without RXFIFO_OVERRUN_EN to match the DUT.
// ----------------------------------------------------------------------------
module tb_rs232_rx_fifo;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rs232_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

   rs232_rx_fifo #(.DEPTH_LOG2(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Receiver model: hold the byte until done, then drop rdy one edge later.
   task automatic push(input logic [7:0] b);
      logic got;
      got = 1'b0;
      bus.rx_data = b;
      bus.rx_rdy  = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (bus.rx_done) got = 1'b1;
      end
      check("push_done", {31'd0, got}, 32'd1);
      tick();
      bus.rx_rdy = 1'b0;
      tick();
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      check(tag, {24'd0, bus.dout}, {24'd0, exp});
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
   endtask

   initial begin
      logic seen;
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b0;
      bus.rx_data = 8'h00;
      bus.rx_rdy  = 1'b0;
      bus.rd      = 1'b0;
      bus.clr_ovf = 1'b0;

      // Reset state
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("rst_rdy",     {31'd0, bus.rdy},     32'd0);
      check("rst_count",   {27'd0, bus.count},   32'd0);
      check("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
      check("rst_ovf",     {31'd0, bus.ovf},     32'd0);

      // Single byte A5: one done pulse right after the capture edge
      bus.rx_data = 8'hA5;
      bus.rx_rdy  = 1'b1;
      tick();
      check("a5_done",  {31'd0, bus.rx_done}, 32'd1);
      check("a5_rdy",   {31'd0, bus.rdy},     32'd1);
      check("a5_count", {27'd0, bus.count},   32'd1);
      check("a5_dout",  {24'd0, bus.dout},    32'hA5);
      tick();
      bus.rx_rdy = 1'b0;
      check("a5_done_end", {31'd0, bus.rx_done}, 32'd0);
      tick();
      tick();
      check("a5_no_second", {31'd0, bus.rx_done}, 32'd0);
      check("a5_count_hold", {27'd0, bus.count},  32'd1);
      pop_check("a5_pop", 8'hA5);
      check("a5_empty", {31'd0, bus.rdy}, 32'd0);

      // Fill 00..0F (write pointer wraps), then drain in order
      for (int i = 0; i < 16; i++) push(8'(i));
      check("fill_count", {27'd0, bus.count}, 32'd16);
      check("fill_rdy",   {31'd0, bus.rdy},   32'd1);
      for (int i = 0; i < 16; i++) pop_check("fill_seq", 8'(i));
      check("drain_rdy",   {31'd0, bus.rdy},   32'd0);
      check("drain_count", {27'd0, bus.count}, 32'd0);
      push(8'hC3);
      check("wrap_dout", {24'd0, bus.dout}, 32'hC3);
      pop_check("wrap_pop", 8'hC3);

      // Byte 77 arriving at a full FIFO with no pop
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      bus.rx_data = 8'h77;
      bus.rx_rdy  = 1'b1;
`ifdef RXFIFO_OVERRUN_EN
      tick();
      check("ovr_done",  {31'd0, bus.rx_done}, 32'd1);
      check("ovr_ovf",   {31'd0, bus.ovf},     32'd1);
      check("ovr_count", {27'd0, bus.count},   32'd16);
      tick();
      bus.rx_rdy = 1'b0;
      tick();
      tick();
      check("ovr_sticky", {31'd0, bus.ovf}, 32'd1);
      bus.clr_ovf = 1'b1;
      tick();
      bus.clr_ovf = 1'b0;
      check("ovr_clear", {31'd0, bus.ovf}, 32'd0);
      for (int i = 0; i < 16; i++) pop_check("ovr_seq", 8'(8'h10 + i));
      check("ovr_empty", {31'd0, bus.rdy}, 32'd0);
`else
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.rx_done) seen = 1'b1;
      end
      check("stall_no_done", {31'd0, seen},      32'd0);
      check("stall_count",   {27'd0, bus.count}, 32'd16);
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      check("stall_done",  {31'd0, bus.rx_done}, 32'd1);
      check("stall_count2", {27'd0, bus.count},  32'd16);
      check("stall_head",  {24'd0, bus.dout},    32'h11);
      check("stall_ovf",   {31'd0, bus.ovf},     32'd0);
      tick();
      bus.rx_rdy = 1'b0;
      tick();
      tick();
      for (int i = 1; i < 16; i++) pop_check("stall_seq", 8'(8'h10 + i));
      pop_check("stall_last", 8'h77);
      check("stall_empty", {31'd0, bus.rdy}, 32'd0);
`endif

      // Full FIFO, push and pop in the same cycle
      for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
      bus.rx_data = 8'h88;
      bus.rx_rdy  = 1'b1;
      bus.rd      = 1'b1;
      tick();
      bus.rd = 1'b0;
      check("pp_done",  {31'd0, bus.rx_done}, 32'd1);
      check("pp_count", {27'd0, bus.count},   32'd16);
      check("pp_ovf",   {31'd0, bus.ovf},     32'd0);
      check("pp_head",  {24'd0, bus.dout},    32'h21);
      tick();
      bus.rx_rdy = 1'b0;
      tick();
      tick();
      for (int i = 1; i < 16; i++) pop_check("pp_seq", 8'(8'h20 + i));
      pop_check("pp_last", 8'h88);

      // Reads while empty are ignored
      bus.rd = 1'b1;
      repeat (3) tick();
      bus.rd = 1'b0;
      check("empty_rd_count", {27'd0, bus.count}, 32'd0);
      check("empty_rd_rdy",   {31'd0, bus.rdy},   32'd0);
      push(8'h5A);
      check("empty_push_count", {27'd0, bus.count}, 32'd1);
      pop_check("empty_push_dout", 8'h5A);

      // Asynchronous reset in CAP_WAIT with three entries stored
      push(8'h61);
      push(8'h62);
      bus.rx_data = 8'h63;
      bus.rx_rdy  = 1'b1;
      tick();
      check("ar_pre_done",  {31'd0, bus.rx_done}, 32'd1);
      check("ar_pre_count", {27'd0, bus.count},   32'd3);
      #2 rst = 1'b0;
      #1;
      check("ar_count",   {27'd0, bus.count},   32'd0);
      check("ar_rdy",     {31'd0, bus.rdy},     32'd0);
      check("ar_rx_done", {31'd0, bus.rx_done}, 32'd0);
      check("ar_ovf",     {31'd0, bus.ovf},     32'd0);
      #2 rst = 1'b1;
      // Byte still held by the receiver is captured after release
      tick();
      check("ar_recap_done",  {31'd0, bus.rx_done}, 32'd1);
      check("ar_recap_count", {27'd0, bus.count},   32'd1);
      check("ar_recap_dout",  {24'd0, bus.dout},    32'h63);
      tick();
      bus.rx_rdy = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
